// File: rtl/bus_master_arbiter.sv
// ---------------------------------------------------------------------------
// bus_master_arbiter
//
// Merges the CPU instruction-fetch port (read-only) and the data (load/store)
// port onto one bus master interface. One master is granted at a time. The
// grant is held until the bus reports completion with Hready. Read data, an
// ack pulse and an error flag are then returned, registered, to the master
// that owned the transfer.
//
// Optional feature (compile-time macro): ARB_STARVE_GUARD_EN
//   When defined, a 3-bit saturating counter tracks data completions that
//   happen while fetch is waiting. Once it reaches STARVE_LIMIT, the next
//   contested arbitration goes to fetch. When undefined, data always has
//   strict priority and the counter does not exist.
//
// Ports:
//   Hclock, Hreset       clock (rising edge), synchronous active-high reset
//   i_req/i_addr         fetch request (level) and address
//   i_rdata/i_ack/i_err  fetch read data, one-cycle completion pulse, error
//   d_req/d_write/d_size/d_addr/d_wdata
//                        data request, store flag, size, address, store data
//   d_rdata/d_ack/d_err  data read data, one-cycle completion pulse, error
//   Hsize/Hwrite/Hwritedata/Haddress
//                        bus master outputs (parked when idle)
//   Hreaddata/Hresponse/Hready
//                        bus read data, error response, transfer complete
//   busy                 high while a master holds the grant
// ---------------------------------------------------------------------------
module bus_master_arbiter #(
  parameter logic [31:0] PARK_ADDR = 32'hFFFFFFFC
`ifdef ARB_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic        Hclock,
  input  logic        Hreset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_write,
  input  logic        d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        Hsize,
  output logic        Hwrite,
  output logic [31:0] Hwritedata,
  output logic [31:0] Haddress,
  input  logic [31:0] Hreaddata,
  input  logic        Hresponse,
  input  logic        Hready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state_reg;

  // A master's request is ignored during its own ack cycle; the req level is
  // still high there and would otherwise be issued a second time.
  logic i_elig;
  logic d_elig;
  logic pick_i;

  assign i_elig = i_req & ~i_ack;
  assign d_elig = d_req & ~d_ack;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_reg;
  logic       starved;

  assign starved = ({29'd0, starve_cnt_reg} >= STARVE_LIMIT);

  // Counts data completions that fetch had to sit through; a completed fetch
  // resets the count.
  always_ff @(posedge Hclock) begin
    if (Hreset) begin
      starve_cnt_reg <= 3'd0;
    end else if (state_reg == GNT_I && Hready) begin
      starve_cnt_reg <= 3'd0;
    end else if (state_reg == GNT_D && Hready && i_req) begin
      if (starve_cnt_reg != 3'd7) begin
        starve_cnt_reg <= starve_cnt_reg + 3'd1;
      end
    end
  end

  // Fetch wins when alone, or when contested after too many data grants.
  assign pick_i = i_elig & (~d_elig | starved);
`else
  // Strict data priority: fetch only wins when data is not eligible.
  assign pick_i = i_elig & ~d_elig;
`endif

  // Arbitration, grant holding and registered completion outputs.
  always_ff @(posedge Hclock) begin
    if (Hreset) begin
      state_reg <= IDLE;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Hresponse is deliberately ignored here: the parked address
          // always produces a meaningless no-device error.
          if (pick_i) begin
            state_reg <= GNT_I;
          end else if (d_elig) begin
            state_reg <= GNT_D;
          end
        end
        GNT_I: begin
          if (Hready) begin
            i_rdata   <= Hresponse ? 32'd0 : Hreaddata;
            i_err     <= Hresponse;
            i_ack     <= 1'b1;
            state_reg <= IDLE;
          end
        end
        GNT_D: begin
          if (Hready) begin
            d_rdata   <= Hresponse ? 32'd0 : Hreaddata;
            d_err     <= Hresponse;
            d_ack     <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs follow the granted master's inputs directly, so the address
  // phase starts in the grant cycle itself. The master holds its inputs stable
  // while granted, so these stay stable across Hready=0 cycles.
  always_comb begin
    Haddress   = PARK_ADDR;
    Hwrite     = 1'b0;
    Hsize      = 1'b0;
    Hwritedata = 32'd0;
    case (state_reg)
      GNT_I: begin
        Haddress = i_addr;
      end
      GNT_D: begin
        Haddress   = d_addr;
        Hwrite     = d_write;
        Hsize      = d_size;
        Hwritedata = d_wdata;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_bus_master_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for bus_master_arbiter.
// Directed table of single transactions, hand-written multi-cycle sequences
// (simultaneous requests, reset mid-transfer), then randomized masters and an
// address-derived bus slave checked against a rule-level reference model.
// ---------------------------------------------------------------------------
module tb_bus_master_arbiter;

  localparam logic [31:0] PARK = 32'hFFFFFFFC;

  logic        Hclock;
  logic        Hreset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_write;
  logic        d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        Hsize;
  logic        Hwrite;
  logic [31:0] Hwritedata;
  logic [31:0] Haddress;
  logic [31:0] Hreaddata;
  logic        Hresponse;
  logic        Hready;
  logic        busy;

  // Slave model: either directly driven values, or data/error derived from
  // the current bus address.
  logic        auto_slave;
  logic [31:0] slave_rdata;
  logic        slave_resp;

  int total = 0;
  int bad   = 0;

  bus_master_arbiter dut (
    .Hclock     (Hclock),
    .Hreset     (Hreset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ack      (i_ack),
    .i_err      (i_err),
    .d_req      (d_req),
    .d_write    (d_write),
    .d_size     (d_size),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .d_err      (d_err),
    .Hsize      (Hsize),
    .Hwrite     (Hwrite),
    .Hwritedata (Hwritedata),
    .Haddress   (Haddress),
    .Hreaddata  (Hreaddata),
    .Hresponse  (Hresponse),
    .Hready     (Hready),
    .busy       (busy)
  );

  initial Hclock = 1'b0;
  always #5 Hclock = ~Hclock;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A1234;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[31:28] == 4'hE);
  endfunction

  always_comb begin
    if (auto_slave) begin
      Hreaddata = mem_data(Haddress);
      Hresponse = mem_err(Haddress);
    end else begin
      Hreaddata = slave_rdata;
      Hresponse = slave_resp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic        is_data;
    logic        wr;
    logic        sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic        bus_err;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_hwrite;
    logic        exp_hsize;
    logic [31:0] exp_hwdata;
  } vec_t;

  vec_t vecs[5];

  // One complete transaction: request in cycle 0, grant in cycle 1, waits
  // Hready=0 cycles, then completion and an ack in the following cycle.
  task automatic run_vec(input vec_t v, input int idx);
    @(posedge Hclock); #1;
    i_req       = !v.is_data;
    i_addr      = v.is_data ? 32'h0BAD0000 : v.addr;
    d_req       = v.is_data;
    d_addr      = v.is_data ? v.addr : 32'h0BAD0004;
    d_write     = v.is_data ? v.wr : 1'b1;
    d_size      = v.is_data ? v.sz : 1'b1;
    d_wdata     = v.is_data ? v.wdata : 32'hBAD0BAD0;
    slave_rdata = v.bus_rdata;
    slave_resp  = v.bus_err;
    Hready      = 1'b0;
    @(negedge Hclock);
    chk("vec_req_cycle_busy", {31'd0, busy}, 32'd0);
    for (int k = 1; k <= v.waits + 1; k++) begin
      @(posedge Hclock); #1;
      Hready = (k == v.waits + 1);
      @(negedge Hclock);
      chk("vec_grant_busy", {31'd0, busy}, 32'd1);
      chk("vec_grant_haddr", Haddress, v.addr);
      chk("vec_grant_hwrite", {31'd0, Hwrite}, {31'd0, v.exp_hwrite});
      chk("vec_grant_hsize", {31'd0, Hsize}, {31'd0, v.exp_hsize});
      chk("vec_grant_hwdata", Hwritedata, v.exp_hwdata);
      chk("vec_grant_noack", {30'd0, i_ack, d_ack}, 32'd0);
    end
    @(posedge Hclock); #1;
    Hready = 1'b0;
    @(negedge Hclock);
    if (v.is_data) begin
      chk("vec_d_ack", {31'd0, d_ack}, 32'd1);
      chk("vec_other_ack", {31'd0, i_ack}, 32'd0);
      chk("vec_d_rdata", d_rdata, v.exp_rdata);
      chk("vec_d_err", {31'd0, d_err}, {31'd0, v.exp_err});
    end else begin
      chk("vec_i_ack", {31'd0, i_ack}, 32'd1);
      chk("vec_other_ack", {31'd0, d_ack}, 32'd0);
      chk("vec_i_rdata", i_rdata, v.exp_rdata);
      chk("vec_i_err", {31'd0, i_err}, {31'd0, v.exp_err});
    end
    chk("vec_ack_busy", {31'd0, busy}, 32'd0);
    chk("vec_ack_parked", Haddress, PARK);
    @(posedge Hclock); #1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge Hclock);
    chk("vec_single_pulse", {30'd0, i_ack, d_ack}, 32'd0);
    chk("vec_no_reissue", {31'd0, busy}, 32'd0);
    $display("vec %0d done: data=%0d addr=%h", idx, v.is_data, v.addr);
  endtask

  // ------------------------------------------------------- random model
  int          owner;        // 0 none, 1 fetch, 2 data
  logic        pi_elig, pd_elig, p_hready, p_ireq;
  logic        last_i_ack, last_d_ack;
  int          starve;
  int          model_i_acks, model_d_acks, dut_i_acks, dut_d_acks;

  function automatic logic [31:0] rand_iaddr();
    logic [31:0] a;
    a        = $urandom;
    a[1:0]   = 2'b00;
    a[27]    = 1'b0;
    a[31:28] = ($urandom_range(0, 7) == 0) ? 4'hE : 4'h1;
    return a;
  endfunction

  function automatic logic [31:0] rand_daddr();
    logic [31:0] a;
    a        = $urandom;
    a[1:0]   = 2'b00;
    a[27]    = 1'b1;
    a[31:28] = ($urandom_range(0, 7) == 0) ? 4'hE : 4'h2;
    return a;
  endfunction

  initial begin
    logic        exp_ia, exp_da, starve_hit;
    logic [31:0] exp_addr, exp_wd;
    logic        exp_wr, exp_sz;

    Hreset = 1'b1;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_write = 1'b0; d_size = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    Hready = 1'b0; auto_slave = 1'b0; slave_rdata = 32'd0; slave_resp = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h1FC00000, 32'h0, 32'h3C08BFC0, 1'b0, 0,
                32'h3C08BFC0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h00000010, 32'hDEADBEEF, 32'h12345678, 1'b0, 3,
                32'h12345678, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h20000000, 32'h0, 32'hAAAA5555, 1'b1, 0,
                32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h1FC00040, 32'h0, 32'h77778888, 1'b1, 2,
                32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h00000040, 32'h55555555, 32'hCAFEF00D, 1'b0, 1,
                32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'h55555555};

    // ---- reset state
    repeat (3) @(posedge Hclock);
    @(negedge Hclock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_errs", {30'd0, i_err, d_err}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_haddr", Haddress, PARK);
    chk("rst_hctl", {30'd0, Hwrite, Hsize}, 32'd0);
    chk("rst_hwdata", Hwritedata, 32'd0);
    $display("reset check done");
    @(posedge Hclock); #1;
    Hreset = 1'b0;

    // ---- table-driven single transactions
    for (int n = 0; n < 5; n++) run_vec(vecs[n], n);

    // ---- both requests raised together: data first, then fetch
    @(posedge Hclock); #1;
    i_req = 1'b1; i_addr = 32'h1FC00100;
    d_req = 1'b1; d_addr = 32'h00000200; d_write = 1'b0; d_size = 1'b0; d_wdata = 32'h0;
    slave_rdata = 32'h11112222; slave_resp = 1'b0; Hready = 1'b1;
    @(negedge Hclock);
    chk("sim_c0_busy", {31'd0, busy}, 32'd0);
    @(posedge Hclock); #1;
    @(negedge Hclock);
    chk("sim_data_first", Haddress, 32'h00000200);
    @(posedge Hclock); #1;
    slave_rdata = 32'h33334444;
    @(negedge Hclock);
    chk("sim_d_ack", {31'd0, d_ack}, 32'd1);
    chk("sim_d_rdata", d_rdata, 32'h11112222);
    chk("sim_no_i_ack_yet", {31'd0, i_ack}, 32'd0);
    chk("sim_gap_busy", {31'd0, busy}, 32'd0);
    @(posedge Hclock); #1;
    d_req = 1'b0;
    @(negedge Hclock);
    chk("sim_fetch_next", Haddress, 32'h1FC00100);
    chk("sim_fetch_busy", {31'd0, busy}, 32'd1);
    @(posedge Hclock); #1;
    @(negedge Hclock);
    chk("sim_i_ack", {31'd0, i_ack}, 32'd1);
    chk("sim_i_rdata", i_rdata, 32'h33334444);
    @(posedge Hclock); #1;
    i_req = 1'b0; Hready = 1'b0;
    @(negedge Hclock);
    chk("sim_i_pulse", {31'd0, i_ack}, 32'd0);
    $display("simultaneous request sequence done");

    // ---- reset during a stalled data grant
    @(posedge Hclock); #1;
    d_req = 1'b1; d_addr = 32'h00000300; d_write = 1'b1; d_wdata = 32'h0F0F0F0F;
    Hready = 1'b0;
    @(posedge Hclock); #1;
    @(negedge Hclock);
    chk("rstmid_granted", {31'd0, busy}, 32'd1);
    @(posedge Hclock); #1;
    Hreset = 1'b1;
    @(posedge Hclock); #1;
    Hreset = 1'b0; d_req = 1'b0;
    @(negedge Hclock);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_no_ack", {31'd0, d_ack}, 32'd0);
    chk("rstmid_parked", Haddress, PARK);
    chk("rstmid_hwrite", {31'd0, Hwrite}, 32'd0);
    @(posedge Hclock); #1;
    @(negedge Hclock);
    chk("rstmid_no_late_ack", {31'd0, d_ack}, 32'd0);
    $display("reset mid-transfer sequence done");

    // ---- randomized masters against the reference model
    @(posedge Hclock); #1;
    Hreset = 1'b1; auto_slave = 1'b1;
    @(posedge Hclock); #1;
    Hreset = 1'b0;
    owner = 0; pi_elig = 1'b0; pd_elig = 1'b0; p_hready = 1'b0; p_ireq = 1'b0;
    last_i_ack = 1'b0; last_d_ack = 1'b0; starve = 0;
    model_i_acks = 0; model_d_acks = 0; dut_i_acks = 0; dut_d_acks = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge Hclock); #1;
      // masters: hold while pending; after an ack drop or issue a new request
      if (i_req) begin
        if (last_i_ack) begin
          if ($urandom_range(0, 1) == 1) i_addr = rand_iaddr();
          else i_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = rand_iaddr();
      end
      if (d_req) begin
        if (last_d_ack) begin
          if ($urandom_range(0, 3) != 0) begin
            d_addr = rand_daddr(); d_write = $urandom_range(0, 1) == 1;
            d_size = $urandom_range(0, 1) == 1; d_wdata = $urandom;
          end else begin
            d_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_addr = rand_daddr(); d_write = $urandom_range(0, 1) == 1;
        d_size = $urandom_range(0, 1) == 1; d_wdata = $urandom;
      end
      Hready = ($urandom_range(0, 3) != 0);

      @(negedge Hclock);
      exp_ia = 1'b0; exp_da = 1'b0; starve_hit = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_hit = (starve >= 4);
`endif
      if (owner == 0) begin
        if (pd_elig && !(pi_elig && starve_hit)) owner = 2;
        else if (pi_elig) owner = 1;
      end else if (p_hready) begin
        if (owner == 1) begin
          exp_ia = 1'b1; starve = 0;
        end else begin
          exp_da = 1'b1;
          if (p_ireq && starve < 7) starve++;
        end
        owner = 0;
      end

      exp_addr = PARK; exp_wr = 1'b0; exp_sz = 1'b0; exp_wd = 32'd0;
      if (owner == 1) exp_addr = i_addr;
      if (owner == 2) begin
        exp_addr = d_addr; exp_wr = d_write; exp_sz = d_size; exp_wd = d_wdata;
      end
      chk("rnd_busy", {31'd0, busy}, {31'd0, owner != 0});
      chk("rnd_haddr", Haddress, exp_addr);
      chk("rnd_hctl", {30'd0, Hwrite, Hsize}, {30'd0, exp_wr, exp_sz});
      chk("rnd_hwdata", Hwritedata, exp_wd);
      chk("rnd_acks", {30'd0, i_ack, d_ack}, {30'd0, exp_ia, exp_da});
      if (exp_ia) begin
        chk("rnd_i_rdata", i_rdata, mem_err(i_addr) ? 32'd0 : mem_data(i_addr));
        chk("rnd_i_err", {31'd0, i_err}, {31'd0, mem_err(i_addr)});
        model_i_acks++;
      end
      if (exp_da) begin
        chk("rnd_d_rdata", d_rdata, mem_err(d_addr) ? 32'd0 : mem_data(d_addr));
        chk("rnd_d_err", {31'd0, d_err}, {31'd0, mem_err(d_addr)});
        model_d_acks++;
      end
      if (i_ack) dut_i_acks++;
      if (d_ack) dut_d_acks++;

      pi_elig    = i_req && !exp_ia;
      pd_elig    = d_req && !exp_da;
      p_hready   = Hready;
      p_ireq     = i_req;
      last_i_ack = exp_ia;
      last_d_ack = exp_da;
    end
    chk("rnd_i_ack_count", dut_i_acks, model_i_acks);
    chk("rnd_d_ack_count", dut_d_acks, model_d_acks);
    $display("random phase done: fetch acks=%0d data acks=%0d", model_i_acks, model_d_acks);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
